// File: rtl/prf_wb_bank_arbiter.sv
// Per-bank round-robin arbitration of writeback requests onto the PRF write ports.
// Winning writes are registered toward the banks and echoed as wb_PR for wakeup/completion.
module prf_wb_bank_arbiter #(
  parameter int RQ_COUNT   = 8,
  parameter int PR_COUNT   = 128,
  parameter int BANK_COUNT = 4,
  parameter int DATA_WIDTH = 32,
  localparam int LOG_PR_COUNT = $clog2(PR_COUNT),
  localparam int LOG_BANK     = $clog2(BANK_COUNT),
  localparam int LOG_RQ       = $clog2(RQ_COUNT),
  localparam int IDX_W        = LOG_PR_COUNT - LOG_BANK
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [RQ_COUNT-1:0]              req_valid_by_rq,
  input  logic [RQ_COUNT*LOG_PR_COUNT-1:0] req_PR_by_rq,
  input  logic [RQ_COUNT*DATA_WIDTH-1:0]   req_data_by_rq,
  output logic [RQ_COUNT-1:0]              req_ready_by_rq,
  output logic [BANK_COUNT-1:0]            bank_wr_valid_by_bank,
  output logic [BANK_COUNT*IDX_W-1:0]      bank_wr_index_by_bank,
  output logic [BANK_COUNT*DATA_WIDTH-1:0] bank_wr_data_by_bank,
  output logic [BANK_COUNT*LOG_PR_COUNT-1:0] wb_PR_by_bank
);

  logic [LOG_PR_COUNT-1:0] pr_w    [RQ_COUNT];
  logic [DATA_WIDTH-1:0]   data_w  [RQ_COUNT];
  logic [RQ_COUNT-1:0]     x0_w;
  logic [RQ_COUNT-1:0]     cand_w  [BANK_COUNT];
  logic [BANK_COUNT-1:0]   gnt_vld_w;
  logic [LOG_RQ-1:0]       gnt_rq_w [BANK_COUNT];

  logic [LOG_RQ-1:0]       rr_ptr_q  [BANK_COUNT];
  logic [LOG_RQ-1:0]       rr_ptr_d  [BANK_COUNT];
  logic [BANK_COUNT-1:0]   wr_vld_q;
  logic [BANK_COUNT-1:0]   wr_vld_d;
  logic [IDX_W-1:0]        wr_idx_q  [BANK_COUNT];
  logic [IDX_W-1:0]        wr_idx_d  [BANK_COUNT];
  logic [DATA_WIDTH-1:0]   wr_data_q [BANK_COUNT];
  logic [DATA_WIDTH-1:0]   wr_data_d [BANK_COUNT];
  logic [LOG_PR_COUNT-1:0] wr_pr_q   [BANK_COUNT];
  logic [LOG_PR_COUNT-1:0] wr_pr_d   [BANK_COUNT];

  always_comb begin
    for (int r = 0; r < RQ_COUNT; r++) begin
      pr_w[r]   = req_PR_by_rq[r*LOG_PR_COUNT +: LOG_PR_COUNT];
      data_w[r] = req_data_by_rq[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // PR 0 is the x0 mapping: always accepted, never competes for a bank.
  always_comb begin
    for (int r = 0; r < RQ_COUNT; r++) begin
      x0_w[r] = req_valid_by_rq[r] && (pr_w[r] == '0);
    end
    for (int b = 0; b < BANK_COUNT; b++) begin
      cand_w[b] = '0;
      for (int r = 0; r < RQ_COUNT; r++) begin
        cand_w[b][r] = req_valid_by_rq[r] && (pr_w[r] != '0) &&
                       (pr_w[r][LOG_BANK-1:0] == LOG_BANK'(b));
      end
    end
  end

  always_comb begin
    logic [LOG_RQ-1:0] probe;
    probe = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      gnt_vld_w[b] = 1'b0;
      gnt_rq_w[b]  = '0;
      for (int i = 0; i < RQ_COUNT; i++) begin
        probe = rr_ptr_q[b] + LOG_RQ'(i);
        if (!gnt_vld_w[b] && cand_w[b][probe]) begin
          gnt_vld_w[b] = 1'b1;
          gnt_rq_w[b]  = probe;
        end
      end
    end
  end

  always_comb begin
    req_ready_by_rq = x0_w;
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (gnt_vld_w[b]) begin
        req_ready_by_rq[gnt_rq_w[b]] = 1'b1;
      end
    end
    if (RST) begin
      req_ready_by_rq = '0;
    end
  end

  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      rr_ptr_d[b]  = rr_ptr_q[b];
      wr_vld_d[b]  = gnt_vld_w[b];
      wr_idx_d[b]  = wr_idx_q[b];
      wr_data_d[b] = wr_data_q[b];
      wr_pr_d[b]   = wr_pr_q[b];
      if (gnt_vld_w[b]) begin
        rr_ptr_d[b]  = gnt_rq_w[b] + LOG_RQ'(1);
        wr_idx_d[b]  = pr_w[gnt_rq_w[b]][LOG_PR_COUNT-1:LOG_BANK];
        wr_data_d[b] = data_w[gnt_rq_w[b]];
        wr_pr_d[b]   = pr_w[gnt_rq_w[b]];
      end
    end
  end

  // Grant -> bank write register boundary; reset drops any pending write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_vld_q <= '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr_q[b]  <= '0;
        wr_idx_q[b]  <= '0;
        wr_data_q[b] <= '0;
        wr_pr_q[b]   <= '0;
      end
    end else begin
      wr_vld_q <= wr_vld_d;
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr_q[b]  <= rr_ptr_d[b];
        wr_idx_q[b]  <= wr_idx_d[b];
        wr_data_q[b] <= wr_data_d[b];
        wr_pr_q[b]   <= wr_pr_d[b];
      end
    end
  end

  always_comb begin
    bank_wr_valid_by_bank = wr_vld_q;
    bank_wr_index_by_bank = '0;
    bank_wr_data_by_bank  = '0;
    wb_PR_by_bank         = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_wr_index_by_bank[b*IDX_W +: IDX_W]               = wr_idx_q[b];
      bank_wr_data_by_bank[b*DATA_WIDTH +: DATA_WIDTH]      = wr_data_q[b];
      wb_PR_by_bank[b*LOG_PR_COUNT +: LOG_PR_COUNT]         = wr_pr_q[b];
    end
  end

`ifndef SYNTHESIS
  // Two live requests to one nonzero PR means rename handed out a PR twice.
  logic dup_pr_w;
  always_comb begin
    dup_pr_w = 1'b0;
    for (int a = 0; a < RQ_COUNT; a++) begin
      for (int c = a + 1; c < RQ_COUNT; c++) begin
        if (req_valid_by_rq[a] && req_valid_by_rq[c] &&
            (pr_w[a] != '0) && (pr_w[a] == pr_w[c])) begin
          dup_pr_w = 1'b1;
        end
      end
    end
  end

  a_unique_pr: assert property (@(posedge CLK) disable iff (RST) !dup_pr_w);
`endif

endmodule
